solitaire_move_player: RTL

// - Move-issuing front end for the peg solitaire engine. Buffers move requests (x, y, direction) from a

---
 rtl/solitaire_move_player.sv | 136 +++++++++++++
 1 files changed

// File: rtl/solitaire_move_player.sv
// Move-issuing front end for the peg solitaire engine: queues (x, y, dir) requests and issues them one at a time.
// Optional macro SOLITAIRE_PLAYER_STATS_EN adds a saturating moves_rejected counter port.
module solitaire_move_player #(
    parameter int         DEPTH   = 4,
    parameter logic [2:0] PARK_XY = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_x,
    input  logic [2:0] in_y,
    input  logic [1:0] in_dir,
    output logic [2:0] eng_piece_x,
    output logic [2:0] eng_piece_y,
    output logic [1:0] eng_direction,
    input  logic [5:0] eng_piece_count,
    input  logic       eng_game_over,
    output logic       resp_valid,
    output logic       resp_accepted,
    output logic [5:0] resp_count,
    output logic       busy,
`ifdef SOLITAIRE_PLAYER_STATS_EN
    output logic [7:0] moves_rejected,
`endif
    output logic [5:0] moves_accepted
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

    state_t      state;
    logic [7:0]  fifo_mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic [7:0]  head;
    logic [5:0]  snap_count;
    logic        accepted;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state == IDLE) && !empty;
    assign head     = fifo_mem[rd_ptr[AW-1:0]];
    assign busy     = !empty || (state != IDLE);
    assign accepted = (eng_piece_count == (snap_count - 6'd1));

    // Queue storage carries data only, so it is left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {in_x, in_y, in_dir};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pop && !eng_game_over) begin
            snap_count <= eng_piece_count;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            eng_piece_x    <= PARK_XY;
            eng_piece_y    <= PARK_XY;
            eng_direction  <= 2'b00;
            resp_valid     <= 1'b0;
            resp_accepted  <= 1'b0;
            resp_count     <= 6'd0;
            moves_accepted <= 6'd0;
`ifdef SOLITAIRE_PLAYER_STATS_EN
            moves_rejected <= 8'd0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (!eng_game_over) begin
                            eng_piece_x   <= head[7:5];
                            eng_piece_y   <= head[4:2];
                            eng_direction <= head[1:0];
                            state         <= ISSUE;
                        end else begin
                            // Game over: drain the move as rejected without touching the engine
                            resp_valid    <= 1'b1;
                            resp_accepted <= 1'b0;
                            resp_count    <= eng_piece_count;
`ifdef SOLITAIRE_PLAYER_STATS_EN
                            moves_rejected <= sat_inc8(moves_rejected);
`endif
                        end
                    end
                end
                ISSUE: begin
                    eng_piece_x   <= PARK_XY;
                    eng_piece_y   <= PARK_XY;
                    eng_direction <= 2'b00;
                    state         <= CHECK;
                end
                CHECK: begin
                    resp_valid     <= 1'b1;
                    resp_accepted  <= accepted;
                    resp_count     <= eng_piece_count;
                    moves_accepted <= moves_accepted + {5'd0, accepted};
`ifdef SOLITAIRE_PLAYER_STATS_EN
                    if (!accepted) moves_rejected <= sat_inc8(moves_rejected);
`endif
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
